// File: rtl/gpio_pkg.sv
// Shared GPIO constants: pin-count ceiling and direction encodings.
package gpio_pkg;

  localparam int unsigned GPIO_MAX_PINS = 32;
  localparam logic        DIR_IN        = 1'b0;
  localparam logic        DIR_OUT       = 1'b1;

endpackage

// File: rtl/gpio_pin_sync.sv
// Per-pin input sampling and change detection.
// Define GPIO_NPINS_SYNC_EN to sample the pin through a 2-flop synchronizer.
module gpio_pin_sync
  import gpio_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pin_i,
  input  logic dir_i,
  output logic in_s_o,
  output logic edge_o
);

`ifdef GPIO_NPINS_SYNC_EN
  logic sync1_q, sync2_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pin_i;
      sync2_q <= sync1_q;
    end
  end

  assign in_s_o = sync2_q;
`else
  assign in_s_o = pin_i;
`endif

  logic prev_q;
  logic dir_prev_q;
  logic armed_q;

  // armed_q suppresses the compare against the reset value of prev_q.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prev_q     <= 1'b0;
      dir_prev_q <= DIR_IN;
      armed_q    <= 1'b0;
    end else begin
      prev_q     <= in_s_o;
      dir_prev_q <= dir_i;
      armed_q    <= 1'b1;
    end
  end

  // Mask also on the previous direction so an output->input switch cannot flag the old level.
  assign edge_o = armed_q & (in_s_o ^ prev_q) & (dir_i == DIR_IN) & (dir_prev_q == DIR_IN);

endmodule

// File: rtl/gpio_npins.sv
// N-pin GPIO block: per-pin direction mux, input change flags and OR-ed interrupt.
// Define GPIO_NPINS_SYNC_EN to insert a 2-flop synchronizer on every input pin.
module gpio_npins
  import gpio_pkg::*;
#(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] data_in,
  input  logic [N-1:0] dir_in,
  input  logic [N-1:0] gpio_pins,
  output logic [N-1:0] gpio_pins_out,
  output logic [N-1:0] edge_out,
  output logic         irq
);

  if (N < 1 || N > GPIO_MAX_PINS) begin : g_bad_n
    $error("gpio_npins: N out of range");
  end

  logic [N-1:0] in_s;
  logic [N-1:0] edge_d;
  logic [N-1:0] out_d;
  logic [N-1:0] out_q;
  logic [N-1:0] edge_q;
  logic         irq_q;

  for (genvar i = 0; i < N; i++) begin : g_pin
    gpio_pin_sync u_pin_sync (
      .clk_i  (clk),
      .rst_ni (reset),
      .pin_i  (gpio_pins[i]),
      .dir_i  (dir_in[i]),
      .in_s_o (in_s[i]),
      .edge_o (edge_d[i])
    );
  end

  always_comb begin
    out_d = '0;
    for (int i = 0; i < int'(N); i++) begin
      out_d[i] = (dir_in[i] == DIR_OUT) ? data_in[i] : in_s[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q  <= '0;
      edge_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      edge_q <= edge_d;
      irq_q  <= |edge_d;
    end
  end

  assign gpio_pins_out = out_q;
  assign edge_out      = edge_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_gpio_npins.sv
// Self-checking bench for gpio_npins: behavioural model plus directed literal checks.
module tb_gpio_npins;

  localparam int N = 16;
`ifdef GPIO_NPINS_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] data_in, dir_in, gpio_pins;
  logic [N-1:0] gpio_pins_out, edge_out;
  logic         irq;

  int total = 0;
  int bad   = 0;

  gpio_npins #(.N(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .dir_in        (dir_in),
    .gpio_pins     (gpio_pins),
    .gpio_pins_out (gpio_pins_out),
    .edge_out      (edge_out),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, got, want, $time);
    end
  endtask

  // Model: pin samples age through a history; in_s is the sample LAT-1 edges old.
  logic [N-1:0] hist [3];
  logic [N-1:0] m_prev, m_dprev, m_out, m_edge;
  logic         m_irq;
  bit           m_armed = 0;
  bit           m_valid = 0;

  always @(posedge clk) begin
    logic [N-1:0] ins;
    if (!reset) begin
      for (int k = 0; k < 3; k++) hist[k] = '0;
      m_prev = '0; m_dprev = '0; m_out = '0; m_edge = '0; m_irq = 1'b0;
      m_armed = 0;
    end else begin
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = gpio_pins;
      ins = hist[LAT-1];
      for (int b = 0; b < N; b++) begin
        m_out[b]  = dir_in[b] ? data_in[b] : ins[b];
        m_edge[b] = m_armed && (ins[b] != m_prev[b]) && !dir_in[b] && !m_dprev[b];
      end
      m_irq   = (m_edge != '0);
      m_prev  = ins;
      m_dprev = dir_in;
      m_armed = 1;
    end
    m_valid = 1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_out",  32'(gpio_pins_out), 32'(m_out));
      chk("model_edge", 32'(edge_out),      32'(m_edge));
      chk("model_irq",  32'(irq),           32'(m_irq));
    end
  end

  task automatic step(input logic rst, input logic [N-1:0] pins, input logic [N-1:0] dir,
                      input logic [N-1:0] data);
    reset = rst; gpio_pins = pins; dir_in = dir; data_in = data;
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] vp [6] = '{16'h1234, 16'h1234, 16'hFFFF, 16'h0F0F, 16'h0F0E, 16'h0000};
  logic [N-1:0] vd [6] = '{16'h0000, 16'h00FF, 16'h00FF, 16'hFF00, 16'h0000, 16'h0000};
  logic [N-1:0] vq [6] = '{16'hBEEF, 16'hBEEF, 16'h1357, 16'h2468, 16'h9999, 16'h0000};

  initial begin
    reset = 1'b0; gpio_pins = '0; dir_in = '0; data_in = '0;
`ifndef GPIO_NPINS_SYNC_EN
    step(0, 16'h00FF, 16'h0000, 16'h0000);
    step(0, 16'h00FF, 16'h0000, 16'h0000);
    chk("rst_out",  32'(gpio_pins_out), 32'h0);
    chk("rst_edge", 32'(edge_out),      32'h0);
    chk("rst_irq",  32'(irq),           32'h0);
    // First edge after release must not compare against the reset value.
    step(1, 16'h00FF, 16'h0000, 16'h0000);
    chk("rel_out",  32'(gpio_pins_out), 32'h00FF);
    chk("rel_edge", 32'(edge_out),      32'h0);
    chk("rel_irq",  32'(irq),           32'h0);
    step(0, 16'h0000, 16'h0000, 16'h0000);
    step(1, 16'h0000, 16'h0000, 16'h0000);
    chk("rel2_out",  32'(gpio_pins_out), 32'h0);
    chk("rel2_edge", 32'(edge_out),      32'h0);
    step(1, 16'hAAAA, 16'h0000, 16'h0000);
    chk("in_out",  32'(gpio_pins_out), 32'hAAAA);
    chk("in_edge", 32'(edge_out),      32'hAAAA);
    chk("in_irq",  32'(irq),           32'h1);
    step(1, 16'hAAAA, 16'h0000, 16'h0000);
    chk("in_edge_clr", 32'(edge_out), 32'h0);
    chk("in_irq_clr",  32'(irq),      32'h0);
    step(1, 16'hAAAA, 16'hF0F0, 16'h5555);
    chk("mix_out", 32'(gpio_pins_out), 32'h5A5A);
    step(1, 16'hAAAA, 16'hFFFF, 16'hCCCC);
    chk("outp_out1", 32'(gpio_pins_out), 32'hCCCC);
    step(1, 16'h5555, 16'hFFFF, 16'hFF00);
    chk("outp_out2", 32'(gpio_pins_out), 32'hFF00);
    chk("outp_edge", 32'(edge_out),      32'h0);
    chk("outp_irq",  32'(irq),           32'h0);
    step(1, 16'hAAAA, 16'hFFFF, 16'hFF00);
    chk("outp_edge2", 32'(edge_out), 32'h0);
    // Output->input switch coincident with a level change is masked for that cycle.
    step(1, 16'h5555, 16'h0000, 16'hFF00);
    chk("sw_out",  32'(gpio_pins_out), 32'h5555);
    chk("sw_edge", 32'(edge_out),      32'h0);
    chk("sw_irq",  32'(irq),           32'h0);
    step(1, 16'h0000, 16'h0000, 16'hFF00);
    chk("sw_edge2", 32'(edge_out), 32'h5555);
    chk("sw_irq2",  32'(irq),      32'h1);
    step(1, 16'h0000, 16'hFFFF, 16'hFF00);
    step(0, 16'h0000, 16'hFFFF, 16'hFF00);
    chk("mid_rst_out", 32'(gpio_pins_out), 32'h0);
    step(1, 16'h0000, 16'hFFFF, 16'hFF00);
    chk("mid_rel_out", 32'(gpio_pins_out), 32'hFF00);
    for (int v = 0; v < 6; v++) step(1, vp[v], vd[v], vq[v]);
    step(1, 16'h0001, 16'h0000, 16'h0000);
    chk("tail_edge", 32'(edge_out), 32'h0001);
`else
    step(0, 16'h0000, 16'h0000, 16'h0000);
    step(1, 16'h0000, 16'h0000, 16'h0000);
    chk("rst_out",  32'(gpio_pins_out), 32'h0);
    chk("rst_edge", 32'(edge_out),      32'h0);
    chk("rst_irq",  32'(irq),           32'h0);
    step(1, 16'h0000, 16'h0000, 16'h0000);
    step(1, 16'h0000, 16'h0000, 16'h0000);
    step(1, 16'h0001, 16'h0000, 16'h0000);
    chk("sync_e1_out",  32'(gpio_pins_out), 32'h0);
    chk("sync_e1_edge", 32'(edge_out),      32'h0);
    step(1, 16'h0001, 16'h0000, 16'h0000);
    chk("sync_e2_out",  32'(gpio_pins_out), 32'h0);
    chk("sync_e2_edge", 32'(edge_out),      32'h0);
    step(1, 16'h0001, 16'h0000, 16'h0000);
    chk("sync_e3_out",  32'(gpio_pins_out), 32'h1);
    chk("sync_e3_edge", 32'(edge_out),      32'h1);
    chk("sync_e3_irq",  32'(irq),           32'h1);
    step(1, 16'h0001, 16'h0000, 16'h0000);
    chk("sync_e4_edge", 32'(edge_out), 32'h0);
    step(1, 16'h0001, 16'hF0F0, 16'h5555);
    chk("sync_mix_out", 32'(gpio_pins_out), 32'h5051);
    for (int v = 0; v < 6; v++) step(1, vp[v], vd[v], vq[v]);
    step(0, 16'h0000, 16'hFFFF, 16'hFF00);
    chk("mid_rst_out", 32'(gpio_pins_out), 32'h0);
    step(1, 16'h0000, 16'hFFFF, 16'hFF00);
    chk("mid_rel_out", 32'(gpio_pins_out), 32'hFF00);
`endif
    step(1, 16'h0000, 16'h0000, 16'h0000);
    step(1, 16'h0000, 16'h0000, 16'h0000);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
